// File: rtl/keyed_stream_cipher.sv
// Byte-serial keyed substitution cipher (encrypt/decrypt) with a two-stage valid/ready pipeline.
// Optional out-of-alphabet counter port err_cnt is built only when KSC_ERR_CNT_EN is defined.
module keyed_stream_cipher #(
    parameter int         KEY_LEN  = 7,
    parameter logic [7:0] ALPHA_LO = 8'h20,
    parameter logic [7:0] ALPHA_HI = 8'h7E,
    localparam int        KAW      = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_we,
    input  logic [KAW-1:0] key_addr,
    input  logic [7:0]     key_data,
    input  logic           mode,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [7:0]     s_data,
    input  logic           s_last,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [7:0]     m_data,
    output logic           m_last,
    output logic           m_err,
`ifdef KSC_ERR_CNT_EN
    output logic [15:0]    err_cnt,
`endif
    output logic           msg_active
);

    localparam logic [8:0] ALPHA_N = {1'b0, ALPHA_HI} - {1'b0, ALPHA_LO} + 9'd1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    function automatic logic [7:0] enc_fn(input logic [7:0] idx, input logic [7:0] kr);
        logic [8:0] r;
        r = {1'b0, idx} + {1'b0, kr};
        if (r >= ALPHA_N) r = r - ALPHA_N;
        return r[7:0] + ALPHA_LO;
    endfunction

    function automatic logic [7:0] dec_fn(input logic [7:0] idx, input logic [7:0] kr);
        logic signed [9:0] r;
        r = $signed({2'b00, idx}) - $signed({2'b00, kr});
        if (r < 0) r = r + $signed({1'b0, ALPHA_N});
        return r[7:0] + ALPHA_LO;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]     key_q [KEY_LEN];
    logic [KAW-1:0] kp_q, kp_d;
    state_t         state_q;

    logic           vld_p1_q, mode_p1_q, last_p1_q, in_p1_q;
    logic [7:0]     data_p1_q, kr_p1_q;
    logic           vld_p2_q, last_p2_q, err_p2_q;
    logic [7:0]     data_p2_q;

    logic           ld_p1, ld_p2, s_acc, s_in;
    logic [7:0]     kr_p0, idx_p1, res_p1;
    logic [8:0]     kmod_p0;

    assign ld_p2   = !vld_p2_q || m_ready;
    assign ld_p1   = !vld_p1_q || ld_p2;
    assign s_ready = ld_p1;
    assign s_acc   = s_valid && s_ready;
    assign s_in    = (s_data >= ALPHA_LO) && (s_data <= ALPHA_HI);

    // Key byte reduced modulo the alphabet size before it enters the pipeline
    assign kmod_p0 = {1'b0, key_q[kp_q]} % ALPHA_N;
    assign kr_p0   = kmod_p0[7:0];

    always_comb begin
        kp_d = kp_q;
        if (s_acc) begin
            if (s_last)
                kp_d = '0;
            else if (s_in)
                kp_d = (kp_q == KAW'(KEY_LEN - 1)) ? '0 : kp_q + KAW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_LEN; i++) key_q[i] <= '0;
        end else if (key_we && (32'(key_addr) < KEY_LEN)) begin
            key_q[key_addr] <= key_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_q    <= '0;
            state_q <= IDLE;
        end else begin
            kp_q <= kp_d;
            if (s_acc) state_q <= s_last ? IDLE : ACTIVE;
        end
    end

    assign msg_active = (state_q == ACTIVE);

    // Stage 1: capture byte, direction, framing, range flag and reduced key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1_q <= 1'b0;
        else if (ld_p1)
            vld_p1_q <= s_valid;
    end

    always_ff @(posedge clk) begin
        if (s_acc) begin
            data_p1_q <= s_data;
            mode_p1_q <= mode;
            last_p1_q <= s_last;
            in_p1_q   <= s_in;
            kr_p1_q   <= kr_p0;
        end
    end

    assign idx_p1 = data_p1_q - ALPHA_LO;
    assign res_p1 = !in_p1_q  ? data_p1_q :
                    mode_p1_q ? dec_fn(idx_p1, kr_p1_q) : enc_fn(idx_p1, kr_p1_q);

    // Stage 2: output register, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            last_p2_q <= 1'b0;
            err_p2_q  <= 1'b0;
        end else if (ld_p2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= res_p1;
                last_p2_q <= last_p1_q;
                err_p2_q  <= !in_p1_q;
            end
        end
    end

    assign m_valid = vld_p2_q;
    assign m_data  = data_p2_q;
    assign m_last  = last_p2_q;
    assign m_err   = err_p2_q;

`ifdef KSC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (vld_p2_q && m_ready && err_p2_q)
            err_cnt_q <= sat_inc16(err_cnt_q);
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_keyed_stream_cipher.sv
// Directed bench for keyed_stream_cipher with KEY_LEN=3 and key "KEY" (0x4B 0x45 0x59).
module tb_keyed_stream_cipher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_we = 1'b0;
    logic [1:0] key_addr = '0;
    logic [7:0] key_data = '0;
    logic       mode = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_err;
    logic       msg_active;
`ifdef KSC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [7:0] rxd[$];
    logic       rxl[$];
    logic       rxe[$];

    keyed_stream_cipher #(.KEY_LEN(3), .ALPHA_LO(8'h20), .ALPHA_HI(8'h7E)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
        .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_err(m_err),
`ifdef KSC_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .msg_active(msg_active)
    );

    always #5 clk = ~clk;

    // Handshakes are sampled mid-cycle; the transfer itself happens on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                rxd.push_back(m_data);
                rxl.push_back(m_last);
                rxe.push_back(m_err);
            end
            if (s_valid && s_ready) acc_cnt++;
        end
    end

    task automatic push_beat(input logic [7:0] d, input logic l, input logic md);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        mode    = md;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout s_ready=%0b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rxd.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (rxd.size() < n) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout got=%0d required=%0d", rxd.size(), n);
            while (rxd.size() < n) begin
                rxd.push_back(8'hxx);
                rxl.push_back(1'bx);
                rxe.push_back(1'bx);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rxd.delete();
        rxl.delete();
        rxe.delete();
    endtask

    task automatic write_key(input logic [1:0] a, input logic [7:0] d);
        key_we   = 1'b1;
        key_addr = a;
        key_data = d;
        @(posedge clk);
        #1;
        key_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        got = {s_ready, m_valid, m_data, m_last, msg_active};
        checks++;
        if (got !== 12'b1_0_00000000_0_0 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got=%h err=%b required=%h err=0", got, m_err, 12'h800);
        end
`ifdef KSC_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_cnt got=%h required=0000", err_cnt);
        end
`endif
    endtask

    task automatic test_encrypt();
        logic [7:0] din[4];
        logic [7:0] exp[4];
        din = '{8'h40, 8'h23, 8'h24, 8'h25};
        exp = '{8'h2C, 8'h68, 8'h7D, 8'h70};
        clear_rx();
        for (int i = 0; i < 4; i++) begin
            push_beat(din[i], i == 3, 1'b0);
            if (i == 0) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_cycle1 m_valid=%b required 0", m_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'h2C) begin
                    errors++;
                    $display("FAIL latency_cycle2 m_valid=%b m_data=%h required 1 2c", m_valid, m_data);
                end
            end
        end
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxd[i] !== exp[i] || rxl[i] !== (i == 3) || rxe[i] !== 1'b0) begin
                errors++;
                $display("FAIL encrypt[%0d] data=%h last=%b err=%b required %h %b 0",
                         i, rxd[i], rxl[i], rxe[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_decrypt();
        logic [7:0] din[4];
        logic [7:0] exp[4];
        din = '{8'h2C, 8'h68, 8'h7D, 8'h70};
        exp = '{8'h40, 8'h23, 8'h24, 8'h25};
        clear_rx();
        for (int i = 0; i < 4; i++) push_beat(din[i], i == 3, 1'b1);
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxd[i] !== exp[i] || rxl[i] !== (i == 3) || rxe[i] !== 1'b0) begin
                errors++;
                $display("FAIL decrypt[%0d] data=%h last=%b err=%b required %h %b 0",
                         i, rxd[i], rxl[i], rxe[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_out_of_alphabet();
        logic [7:0] din[3];
        logic [7:0] exp[3];
        logic       eer[3];
        din = '{8'h40, 8'h0A, 8'h23};
        exp = '{8'h2C, 8'h0A, 8'h68};
        eer = '{1'b0, 1'b1, 1'b0};
        clear_rx();
        for (int i = 0; i < 3; i++) push_beat(din[i], i == 2, 1'b0);
        wait_rx(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxd[i] !== exp[i] || rxe[i] !== eer[i]) begin
                errors++;
                $display("FAIL oob[%0d] data=%h err=%b required %h %b", i, rxd[i], rxe[i], exp[i], eer[i]);
            end
        end
`ifdef KSC_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL oob_err_cnt got=%0d required 1", err_cnt);
        end
`endif
    endtask

    task automatic test_boundaries();
        logic [7:0] din[4];
        logic [7:0] exp[4];
        logic       eer[4];
        din = '{8'h1F, 8'h20, 8'h7E, 8'h7F};
        exp = '{8'h1F, 8'h6B, 8'h64, 8'h7F};
        eer = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_rx();
        for (int i = 0; i < 4; i++) push_beat(din[i], i == 3, 1'b0);
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxd[i] !== exp[i] || rxe[i] !== eer[i] || rxl[i] !== (i == 3)) begin
                errors++;
                $display("FAIL bound[%0d] data=%h err=%b last=%b required %h %b %b",
                         i, rxd[i], rxe[i], rxl[i], exp[i], eer[i], (i == 3));
            end
        end
`ifdef KSC_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bound_err_cnt got=%0d required 3", err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back_backpressure();
        logic [7:0] din[6];
        logic [7:0] exp[6];
        int         acc0;
        din = '{8'h40, 8'h23, 8'h24, 8'h25, 8'h40, 8'h23};
        exp = '{8'h2C, 8'h68, 8'h7D, 8'h70, 8'h26, 8'h7C};
        clear_rx();
        acc0 = acc_cnt;
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) push_beat(din[i], i == 5, 1'b0);
            end
            begin
                logic [7:0] held;
                logic       have;
                have = 1'b0;
                held = '0;
                repeat (5) begin
                    @(negedge clk);
                    if (m_valid) begin
                        if (have) begin
                            checks++;
                            if (m_data !== held) begin
                                errors++;
                                $display("FAIL stall_hold m_data=%h required %h", m_data, held);
                            end
                        end
                        held = m_data;
                        have = 1'b1;
                    end
                end
                checks++;
                if (acc_cnt - acc0 !== 2) begin
                    errors++;
                    $display("FAIL stall_accepts got=%0d required 2", acc_cnt - acc0);
                end
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_s_ready got=%b required 0", s_ready);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        wait_rx(6);
        checks++;
        if (rxd.size() !== 6) begin
            errors++;
            $display("FAIL bp_count got=%0d required 6", rxd.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rxd[i] !== exp[i] || rxl[i] !== (i == 5)) begin
                errors++;
                $display("FAIL bp[%0d] data=%h last=%b required %h %b", i, rxd[i], rxl[i], exp[i], (i == 5));
            end
        end
    endtask

    task automatic test_msg_boundary();
        logic [7:0] exp[3];
        exp = '{8'h2C, 8'h68, 8'h2C};
        clear_rx();
        push_beat(8'h40, 1'b0, 1'b0);
        checks++;
        if (msg_active !== 1'b1) begin
            errors++;
            $display("FAIL msg_active_first got=%b required 1", msg_active);
        end
        push_beat(8'h23, 1'b1, 1'b0);
        checks++;
        if (msg_active !== 1'b0) begin
            errors++;
            $display("FAIL msg_active_last got=%b required 0", msg_active);
        end
        push_beat(8'h40, 1'b1, 1'b0);
        checks++;
        if (msg_active !== 1'b0) begin
            errors++;
            $display("FAIL msg_active_single got=%b required 0", msg_active);
        end
        wait_rx(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxd[i] !== exp[i]) begin
                errors++;
                $display("FAIL msg[%0d] data=%h required %h", i, rxd[i], exp[i]);
            end
        end
    endtask

    task automatic test_mode_mix();
        logic [7:0] din[3];
        logic [7:0] exp[3];
        logic       md[3];
        din = '{8'h40, 8'h68, 8'h24};
        exp = '{8'h2C, 8'h23, 8'h7D};
        md  = '{1'b0, 1'b1, 1'b0};
        clear_rx();
        for (int i = 0; i < 3; i++) push_beat(din[i], i == 2, md[i]);
        wait_rx(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxd[i] !== exp[i]) begin
                errors++;
                $display("FAIL mode_mix[%0d] data=%h required %h", i, rxd[i], exp[i]);
            end
        end
    endtask

    task automatic test_key_collision();
        logic [7:0] exp[4];
        exp = '{8'h2C, 8'h40, 8'h40, 8'h68};
        clear_rx();
        key_we   = 1'b1;
        key_addr = 2'd0;
        key_data = 8'h00;
        push_beat(8'h40, 1'b1, 1'b0);
        key_we = 1'b0;
        write_key(2'd3, 8'h11);
        push_beat(8'h40, 1'b1, 1'b0);
        push_beat(8'h40, 1'b0, 1'b0);
        push_beat(8'h23, 1'b1, 1'b0);
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxd[i] !== exp[i]) begin
                errors++;
                $display("FAIL key_coll[%0d] data=%h required %h", i, rxd[i], exp[i]);
            end
        end
        write_key(2'd0, 8'h4B);
    endtask

    task automatic test_reset_mid_stream();
        clear_rx();
        m_ready = 1'b0;
        push_beat(8'h40, 1'b0, 1'b0);
        push_beat(8'h23, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || msg_active !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset m_valid=%b msg_active=%b required 1 1", m_valid, msg_active);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || msg_active !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset m_valid=%b s_ready=%b msg_active=%b m_data=%h required 0 1 0 00",
                     m_valid, s_ready, msg_active, m_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        clear_rx();
        push_beat(8'h40, 1'b1, 1'b0);
        wait_rx(1);
        checks++;
        if (rxd[0] !== 8'h40 || rxe[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset data=%h err=%b required 40 0", rxd[0], rxe[0]);
        end
`ifdef KSC_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_err_cnt got=%0d required 0", err_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        write_key(2'd0, 8'h4B);
        write_key(2'd1, 8'h45);
        write_key(2'd2, 8'h59);
        test_encrypt();
        test_decrypt();
        test_out_of_alphabet();
        test_boundaries();
        test_back_to_back_backpressure();
        test_msg_boundary();
        test_mode_mix();
        test_key_collision();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
